ledm_scan_ctrl: RTL and testbench
=================================

Name: ledm_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8x5 LED matrix used by the PonG display. Holds a double-buffered frame: software or game logic writes the back bank through a valid/ready port, and the scanner drives the front bank one column at a time. A requested bank swap happens only at a frame boundary, so the display never tears. Sits between the processor/game-logic LED output and the active-low LEDM_R/LEDM_C pins.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
COL_HZ, 1000, column dwell rate; DWELL = CLK_HZ/COL_HZ cycles per column (integer divide, must be > BLANK_CYC+1)
N_COLS, 5, matrix columns; column index width 3 bits
N_ROWS, 8, matrix rows (data width)
BLANK_CYC, 16, anti-ghosting blank cycles at the start of each column period

Ports:
clock_50MHz  in  1  system clock
reset_n  in  1  reset; one clock, asynchronous, active-low
wr_valid  in  1  back-bank write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_col  in  3  target column 0..N_COLS-1
wr_data  in  8  row pattern, bit r = row r lit (active-high)
swap_req  in  1  single-cycle pulse: swap banks at next frame boundary
swap_ack  out  1  single-cycle pulse on the cycle the swap occurs
frame_tick  out  1  single-cycle pulse at every frame boundary
LEDM_R  out  8  row drive, active-low
LEDM_C  out  5  column select, active-low, at most one bit low

Behaviour:
- Storage: two banks of N_COLS x 8 bits; front_sel selects the displayed bank, the other is the back bank.
- Reset: all bank bits 0, front_sel=0, col=0, dwell counter=0, swap pending=0, LEDM_R=8'hFF, LEDM_C=5'h1F, wr_ready=1, swap_ack=0, frame_tick=0. Reset asserted mid-scan returns to this state immediately; pending swaps and banked data are lost.
- Scan FSM states: BLANK, DRIVE.
  - BLANK: dwell counter 0..BLANK_CYC-1; LEDM_C=5'h1F, LEDM_R=8'hFF.
  - DRIVE: dwell counter BLANK_CYC..DWELL-1; LEDM_C=~(1<<col), LEDM_R=~front[col].
  - At dwell counter DWELL-1: counter returns to 0, state goes to BLANK, col increments.
  - col wraps N_COLS-1 -> 0. That wrap cycle is the frame boundary.
- Outputs are registered. Pin values reflect the state/col of the previous cycle, giving one cycle of latency.
- Frame boundary: frame_tick=1 for one cycle.
  - If swap pending, or swap_req is asserted in that same cycle: toggle front_sel, clear pending, pulse swap_ack.
  - After a swap the new back bank holds the old front contents; there is no copy.
- swap_req outside a boundary sets pending. Extra requests while pending merge into one swap.
- Writes: accepted on wr_valid && wr_ready and stored to back[wr_col] on the next edge.
  - wr_col >= N_COLS is accepted and discarded.
  - wr_ready=0 only on the swap cycle, so a write never straddles a bank change. A write presented on that cycle waits and is taken next cycle into the new back bank.
- Frame period = N_COLS*DWELL cycles (250000 at defaults, 200 Hz).

Optional Feature:
Macro LEDM_DIM_EN.
- Defined: adds input brightness[3:0]. Within DRIVE, rows are driven only while (dwell_counter-BLANK_CYC) < ((DWELL-BLANK_CYC)*(brightness+1))>>4; otherwise LEDM_R=8'hFF and LEDM_C still selects the column. brightness=15 equals full drive. brightness is sampled at each column's BLANK->DRIVE transition.
- Undefined: no brightness port; rows are driven for the whole DRIVE phase.

Test Plan:
Use CLK_HZ=1000, COL_HZ=10 (DWELL=100), BLANK_CYC=4 for all scenarios.
1. Reset -> LEDM_R=8'hFF, LEDM_C=5'h1F, wr_ready=1. During scan, every column shows a 4-cycle blank followed by 96 drive cycles with LEDM_R=8'hFF. frame_tick every 500 cycles.
2. Write col2=8'hA5 with no swap -> display unchanged (LEDM_R stays 8'hFF while LEDM_C=5'b11011).
3. Write col2=8'hA5, pulse swap_req mid-frame -> swap_ack coincides with the next frame_tick. In the following frame, LEDM_R=8'h5A whenever LEDM_C=5'b11011.
4. swap_req held on the boundary cycle together with wr_valid (col0=8'hFF) -> wr_ready=0 that cycle. The write lands next cycle in the new back bank, and col0 is still dark on the display.
5. Write wr_col=7 -> accepted, with no change to any column after the swap. Three swap_req pulses in one frame -> exactly one swap_ack.
6. Assert reset_n=0 at cycle 237 mid-DRIVE -> pins return to FF/1F in the same cycle. After release, the scan restarts at col0 BLANK with the banks cleared.
7. (LEDM_DIM_EN) brightness=7 -> 48 of 96 drive cycles have rows low per column. brightness=0 -> 6 cycles.

Source files
------------

// File: rtl/ledm_scan_ctrl.sv
// Double-buffered column-scan controller for the 8x5 PonG LED matrix, with active-low pin drive.
// Optional LEDM_DIM_EN macro adds a brightness input that shortens the row-on time within DRIVE.
module ledm_scan_ctrl #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned COL_HZ    = 1000,
  parameter int unsigned N_COLS    = 5,
  parameter int unsigned N_ROWS    = 8,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic              clock_50MHz,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_col,
  input  logic [N_ROWS-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              frame_tick,
`ifdef LEDM_DIM_EN
  input  logic [3:0]        brightness,
`endif
  output logic [N_ROWS-1:0] LEDM_R,
  output logic [N_COLS-1:0] LEDM_C
);

  localparam int unsigned DWELL     = CLK_HZ / COL_HZ;
  localparam int unsigned DRIVE_CYC = DWELL - BLANK_CYC;
  localparam int unsigned CNT_W     = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_CYC - 1);
  localparam logic [2:0]       ColLast   = 3'(N_COLS - 1);

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         col_q, col_d;
  logic               front_sel_q, front_sel_d;
  logic               pending_q, pending_d;
  logic [N_ROWS-1:0]  bank_q [2][N_COLS];
  logic [N_ROWS-1:0]  ledm_r_q, ledm_r_d;
  logic [N_COLS-1:0]  ledm_c_q, ledm_c_d;
  logic               col_end;
  logic               rows_on;

  assign col_end = (cnt_q == CntLast);

`ifdef LEDM_DIM_EN
  logic [3:0]  bright_q;
  logic [31:0] on_lim;
  logic [31:0] drive_off;

  assign on_lim    = (DRIVE_CYC * (32'(bright_q) + 32'd1)) >> 4;
  assign drive_off = 32'(cnt_q) - BLANK_CYC;
  assign rows_on   = (state_q == StDrive) && (drive_off < on_lim);

  // Brightness is latched once per column so a mid-column change cannot glitch the duty.
  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      bright_q <= 4'hF;
    end else if (state_q == StBlank && cnt_q == BlankLast) begin
      bright_q <= brightness;
    end
  end
`else
  assign rows_on = (state_q == StDrive);
`endif

  // State register
  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StBlank;
      cnt_q       <= '0;
      col_q       <= '0;
      front_sel_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      front_sel_q <= front_sel_d;
      pending_q   <= pending_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    col_d       = col_q;
    case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) state_d = StDrive;
      end
      StDrive: begin
        if (col_end) begin
          state_d = StBlank;
          cnt_d   = '0;
          col_d   = (col_q == ColLast) ? 3'd0 : col_q + 3'd1;
        end
      end
      default: state_d = StBlank;
    endcase
    pending_d = pending_q;
    if (swap_ack) begin
      pending_d = 1'b0;
    end else if (swap_req) begin
      pending_d = 1'b1;
    end
    front_sel_d = front_sel_q ^ swap_ack;
  end

  // Output logic: handshake/pulses are combinational, pin values are registered next
  always_comb begin
    frame_tick = (state_q == StDrive) && col_end && (col_q == ColLast);
    swap_ack   = frame_tick && (pending_q || swap_req);
    wr_ready   = !swap_ack;
    ledm_c_d   = '1;
    if (state_q == StDrive) ledm_c_d = ~(N_COLS'(1) << col_q);
    ledm_r_d   = rows_on ? ~bank_q[front_sel_q][col_q] : '1;
  end

  // Writes target the back bank; out-of-range columns are accepted but dropped.
  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      ledm_r_q <= '1;
      ledm_c_q <= '1;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < N_COLS; c++) begin
          bank_q[b][c] <= '0;
        end
      end
    end else begin
      ledm_r_q <= ledm_r_d;
      ledm_c_q <= ledm_c_d;
      if (wr_valid && wr_ready && (wr_col <= ColLast)) begin
        bank_q[~front_sel_q][wr_col] <= wr_data;
      end
    end
  end

  assign LEDM_R = ledm_r_q;
  assign LEDM_C = ledm_c_q;

endmodule

// File: tb/tb_ledm_scan_ctrl.sv
// Directed bench for ledm_scan_ctrl at DWELL=100, BLANK_CYC=4 (frame = 500 cycles).
// Build with LEDM_DIM_EN defined to also exercise the brightness feature.
module tb_ledm_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_valid = 1'b0;
  logic       swap_req = 1'b0;
  logic [2:0] wr_col = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, swap_ack, frame_tick;
  logic [7:0] ledm_r;
  logic [4:0] ledm_c;
`ifdef LEDM_DIM_EN
  logic [3:0] brightness = 4'hF;
`endif

  int checks = 0;
  int errors = 0;
  int pos = 0;         // DUT scan position (posedges since reset release)
  logic [7:0] disp [5]; // hand-set contents of the displayed bank

  ledm_scan_ctrl #(
    .CLK_HZ(1000), .COL_HZ(10), .N_COLS(5), .N_ROWS(8), .BLANK_CYC(4)
  ) dut (
    .clock_50MHz(clk),
    .reset_n    (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .frame_tick (frame_tick),
`ifdef LEDM_DIM_EN
    .brightness (brightness),
`endif
    .LEDM_R     (ledm_r),
    .LEDM_C     (ledm_c)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] exp_c(int p);
    logic [4:0] one;
    one = 5'b00001;
    if (p % 100 < 4) return 5'h1F;
    return ~(one << ((p % 500) / 100));
  endfunction

  function automatic logic [7:0] exp_r(int p);
    if (p % 100 < 4) return 8'hFF;
    return ~disp[(p % 500) / 100];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) disp[c] = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (ledm_r !== 8'hFF || ledm_c !== 5'h1F) begin
      errors++; $display("FAIL reset_pins got R=%h C=%b want R=ff C=11111", ledm_r, ledm_c);
    end
    checks++;
    if (wr_ready !== 1'b1 || swap_ack !== 1'b0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b ack=%b tick=%b want 1 0 0", wr_ready, swap_ack, frame_tick);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pos = 0;
    #2;
    checks++;
    if (ledm_r !== 8'hFF || ledm_c !== 5'h1F) begin
      errors++; $display("FAIL reset_release got R=%h C=%b want R=ff C=11111", ledm_r, ledm_c);
    end
  endtask

  // Blank frame: 4 blank + 96 drive per column, rows dark, tick at position 499.
  task automatic test_scan();
    while (pos < 500) begin
      step(); #2;
      checks++;
      if (ledm_c !== exp_c(pos-1) || ledm_r !== exp_r(pos-1) || frame_tick !== (pos % 500 == 499)) begin
        errors++;
        $display("FAIL scan pos=%0d got C=%b R=%h tick=%b want C=%b R=%h tick=%b", pos, ledm_c,
                 ledm_r, frame_tick, exp_c(pos-1), exp_r(pos-1), (pos % 500 == 499));
      end
    end
  endtask

  task automatic test_write_no_swap();
    wr_valid = 1'b1; wr_col = 3'd2; wr_data = 8'hA5;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL write_ready got %b want 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    while (pos < 850) begin
      step(); #2;
      checks++;
      if (ledm_c !== exp_c(pos-1) || ledm_r !== exp_r(pos-1)) begin
        errors++;
        $display("FAIL no_swap pos=%0d got C=%b R=%h want C=%b R=%h", pos, ledm_c, ledm_r,
                 exp_c(pos-1), exp_r(pos-1));
      end
    end
  endtask

  task automatic test_swap();
    swap_req = 1'b1;
    #1;
    checks++;
    if (swap_ack !== 1'b0) begin
      errors++; $display("FAIL swap_early got ack=%b want 0", swap_ack);
    end
    step();
    swap_req = 1'b0;
    while (pos < 999) begin
      step(); #2;
      if (pos < 999) begin
        checks++;
        if (swap_ack !== 1'b0 || frame_tick !== 1'b0) begin
          errors++; $display("FAIL swap_wait pos=%0d got ack=%b tick=%b want 0 0", pos, swap_ack, frame_tick);
        end
      end
    end
    checks++;
    if (frame_tick !== 1'b1 || swap_ack !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL swap_boundary got tick=%b ack=%b rdy=%b want 1 1 0", frame_tick, swap_ack, wr_ready);
    end
    disp[2] = 8'hA5;
    while (pos < 1499) begin
      step(); #2;
      checks++;
      if (ledm_c !== exp_c(pos-1) || ledm_r !== exp_r(pos-1)) begin
        errors++;
        $display("FAIL swapped pos=%0d got C=%b R=%h want C=%b R=%h", pos, ledm_c, ledm_r,
                 exp_c(pos-1), exp_r(pos-1));
      end
    end
  endtask

  task automatic test_boundary_write();
    swap_req = 1'b1; wr_valid = 1'b1; wr_col = 3'd0; wr_data = 8'hFF;
    #1;
    checks++;
    if (wr_ready !== 1'b0 || swap_ack !== 1'b1 || frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL bnd_write got rdy=%b ack=%b tick=%b want 0 1 1", wr_ready, swap_ack, frame_tick);
    end
    step();
    swap_req = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || swap_ack !== 1'b0) begin
      errors++; $display("FAIL bnd_retry got rdy=%b ack=%b want 1 0", wr_ready, swap_ack);
    end
    step();
    wr_valid = 1'b0;
    disp[2] = 8'h00;
    while (pos < 2000) begin
      step(); #2;
      checks++;
      if (ledm_c !== exp_c(pos-1) || ledm_r !== exp_r(pos-1)) begin
        errors++;
        $display("FAIL bnd_frame pos=%0d got C=%b R=%h want C=%b R=%h", pos, ledm_c, ledm_r,
                 exp_c(pos-1), exp_r(pos-1));
      end
    end
  endtask

  task automatic test_discard_merge();
    int n_ack;
    n_ack = 0;
    wr_valid = 1'b1; wr_col = 3'd7; wr_data = 8'h3C;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL col7_ready got %b want 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    while (pos < 2499) begin
      step();
      swap_req = (pos == 2100 || pos == 2200 || pos == 2300);
      #2;
      if (swap_ack === 1'b1) n_ack++;
    end
    swap_req = 1'b0;
    checks++;
    if (n_ack !== 1 || swap_ack !== 1'b1) begin
      errors++; $display("FAIL merge got acks=%0d last=%b want acks=1 last=1", n_ack, swap_ack);
    end
    disp[0] = 8'hFF; disp[2] = 8'hA5;
    while (pos < 3000) begin
      step(); #2;
      checks++;
      if (ledm_c !== exp_c(pos-1) || ledm_r !== exp_r(pos-1)) begin
        errors++;
        $display("FAIL merge_frame pos=%0d got C=%b R=%h want C=%b R=%h", pos, ledm_c, ledm_r,
                 exp_c(pos-1), exp_r(pos-1));
      end
    end
  endtask

  task automatic test_async_reset();
    while (pos < 3100) step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    while (pos < 3237) step();
    #2;
    checks++;
    if (ledm_c !== 5'b11011 || ledm_r !== 8'h5A) begin
      errors++; $display("FAIL pre_reset got C=%b R=%h want C=11011 R=5a", ledm_c, ledm_r);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ledm_c !== 5'h1F || ledm_r !== 8'hFF || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got C=%b R=%h rdy=%b want C=11111 R=ff rdy=1", ledm_c, ledm_r, wr_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pos = 0;
    for (int c = 0; c < 5; c++) disp[c] = 8'h00;
    while (pos < 500) begin
      step(); #2;
      checks++;
      if (ledm_c !== exp_c(pos-1) || ledm_r !== exp_r(pos-1) || swap_ack !== 1'b0) begin
        errors++;
        $display("FAIL post_reset pos=%0d got C=%b R=%h ack=%b want C=%b R=%h ack=0", pos, ledm_c,
                 ledm_r, swap_ack, exp_c(pos-1), exp_r(pos-1));
      end
    end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    while (pos < 999) step();
    checks++;
    if (swap_ack !== 1'b1) begin
      errors++; $display("FAIL post_reset_swap got ack=%b want 1", swap_ack);
    end
    while (pos < 1500) begin
      step(); #2;
      checks++;
      if (ledm_c !== exp_c(pos-1) || ledm_r !== exp_r(pos-1)) begin
        errors++;
        $display("FAIL cleared pos=%0d got C=%b R=%h want C=%b R=%h", pos, ledm_c, ledm_r,
                 exp_c(pos-1), exp_r(pos-1));
      end
    end
  endtask

`ifdef LEDM_DIM_EN
  task automatic test_dim();
    int sel, lit;
    wr_valid = 1'b1; wr_col = 3'd1; wr_data = 8'h0F;
    step();
    wr_valid = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    brightness = 4'd7;
    while (pos < 2000) step();
    for (int pass = 0; pass < 2; pass++) begin
      sel = 0; lit = 0;
      if (pass == 1) brightness = 4'd0;
      for (int i = 0; i < 500; i++) begin
        step(); #2;
        if (ledm_c === 5'b11101) begin
          sel++;
          if (ledm_r === 8'hF0) lit++;
        end
      end
      checks++;
      if (sel !== 96) begin
        errors++; $display("FAIL dim_select pass=%0d got %0d want 96", pass, sel);
      end
      checks++;
      if (lit !== ((pass == 0) ? 48 : 6)) begin
        errors++;
        $display("FAIL dim_lit pass=%0d got %0d want %0d", pass, lit, (pass == 0) ? 48 : 6);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_write_no_swap();
    test_swap();
    test_boundary_write();
    test_discard_merge();
    test_async_reset();
`ifdef LEDM_DIM_EN
    test_dim();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
